// File: rtl/mux_serializer_pkg.sv
// mux_serializer_pkg
//   Shared types and helpers for the mux_serializer slice.
//   - state_e : serializer FSM states (IDLE, SHIFT)
//   - idx_w() : bit-index / mux-select width for a given word width
package mux_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Never narrower than one bit, so a WIDTH of 1 or 2 still yields a usable select.
    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mux_serializer_bit_select_mux.sv
// bit_select_mux
//   Combinational WIDTH:1 bit-select multiplexer.
//   Ports:
//     d   [WIDTH]        input word
//     sel [idx_w(WIDTH)] index of the bit to forward
//     y                  selected bit (0 for an out-of-range select)
module bit_select_mux
    import mux_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        d,
    input  logic [idx_w(WIDTH)-1:0] sel,
    output logic                    y
);

    // For non-power-of-two widths the select can encode indices past the
    // top bit; those codes read as 0 instead of an undefined bit.
    always_comb begin
        y = 1'b0;
        if (int'(sel) < WIDTH) begin
            y = d[sel];
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// mux_serializer
//   Parallel-to-serial converter. Takes a WIDTH-bit word over a valid/ready
//   handshake and emits it one bit per handshake on a serial stream.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     up_valid/ready  parallel word handshake, up_data[WIDTH] is the word
//     down_valid      serial bit present
//     down_ready      consumer takes the current bit this cycle
//     down_data       current serial bit
//     down_last       current bit is the final bit of the word
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready. A presented bit (down_data/down_last) holds
//   stable until it is transferred. up_ready may depend combinationally on
//   down_ready: a new word is accepted in the same cycle the last bit of the
//   current word leaves, so consecutive words stream with no idle cycle.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_data,
    output logic             down_last
);

    localparam int              SW       = idx_w(WIDTH);
    localparam logic [SW-1:0]   LAST_IDX = SW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [SW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    phys_idx;
    logic             up_hs;
    logic             down_hs;

    assign down_valid = (state_q == SHIFT);
    assign down_last  = down_valid && (idx_q == LAST_IDX);
    assign down_hs    = down_valid && down_ready;
    assign up_ready   = (state_q == IDLE) || (down_hs && down_last);
    assign up_hs      = up_valid && up_ready;

    // idx_q counts emitted bits; the mux select maps it onto the word.
    assign phys_idx = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;

    bit_select_mux #(
        .WIDTH (WIDTH)
    ) u_bit_select_mux (
        .d   (word_q),
        .sel (phys_idx),
        .y   (down_data)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (up_hs) begin
                    word_d  = up_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (down_hs) begin
                    if (down_last) begin
                        idx_d = '0;
                        if (up_hs) begin
                            // Reload on the last-bit transfer: no bubble.
                            word_d  = up_data;
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer
//   Three serializer instances (8-bit MSB-first, 8-bit LSB-first, 3-bit
//   MSB-first) driven one at a time. The reference model holds the bits still
//   owed by the active instance in a queue: an accepted word appends its bits
//   in emission order, and every serial transfer pops the front.
module tb_mux_serializer;

    logic       clk;
    logic       rst_n;
    logic [2:0] uv;
    logic [2:0] dr;
    logic [7:0] ud;
    logic [2:0] ur;
    logic [2:0] dv;
    logic [2:0] dd;
    logic [2:0] dl;

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_q[$];

    mux_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .up_valid(uv[0]), .up_ready(ur[0]), .up_data(ud),
        .down_valid(dv[0]), .down_ready(dr[0]), .down_data(dd[0]), .down_last(dl[0])
    );

    mux_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .up_valid(uv[1]), .up_ready(ur[1]), .up_data(ud),
        .down_valid(dv[1]), .down_ready(dr[1]), .down_data(dd[1]), .down_last(dl[1])
    );

    mux_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_w3 (
        .clk(clk), .rst_n(rst_n),
        .up_valid(uv[2]), .up_ready(ur[2]), .up_data(ud[2:0]),
        .down_valid(dv[2]), .down_ready(dr[2]), .down_data(dd[2]), .down_last(dl[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle on instance d ----------------
    task automatic step(input int d, input logic v, input logic [7:0] data, input logic r);
        logic ev, el, eu;
        int   w;
        bit   msb;
        w   = (d == 2) ? 3 : 8;
        msb = (d != 1);
        @(negedge clk);
        uv    = '0;
        dr    = '0;
        uv[d] = v;
        dr[d] = r;
        ud    = data;
        #1;
        ev = (exp_q.size() != 0);
        el = (exp_q.size() == 1);
        eu = !ev || (r && el);
        chk($sformatf("down_valid[%0d]", d), dv[d], ev);
        chk($sformatf("up_ready[%0d]", d), ur[d], eu);
        chk($sformatf("down_last[%0d]", d), dl[d], el);
        if (ev) chk($sformatf("down_data[%0d]", d), dd[d], exp_q[0]);
        @(posedge clk);
        if (ev && r) void'(exp_q.pop_front());
        if (v && eu) begin
            for (int k = 0; k < w; k++) begin
                exp_q.push_back(msb ? data[w-1-k] : data[k]);
            end
        end
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(d, 1'b0, 8'h00, 1'b1);
        chk($sformatf("drained[%0d]", d), exp_q.size() == 0, 1'b1);
        step(d, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s down_valid[%0d]", tag, d), dv[d], 1'b0);
            chk($sformatf("%s down_last[%0d]", tag, d), dl[d], 1'b0);
            chk($sformatf("%s down_data[%0d]", tag, d), dd[d], 1'b0);
            chk($sformatf("%s up_ready[%0d]", tag, d), ur[d], 1'b1);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        uv    = '0;
        dr    = '0;
        ud    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, down_ready held high.
        step(0, 1'b1, 8'hA5, 1'b1);
        drain(0);

        // Back-to-back words with up_valid held: second accepted on last bit.
        step(0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) step(0, 1'b1, 8'h3C, 1'b1);
        drain(0);

        // Stall for three cycles while the third bit is presented.
        step(0, 1'b1, 8'hA5, 1'b1);
        step(0, 1'b0, 8'h00, 1'b1);
        step(0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00, 1'b0);
        drain(0);

        // LSB-first, with a second word offered while busy.
        step(1, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 8; i++) step(1, 1'b1, 8'h77, 1'b1);
        drain(1);

        // Asynchronous reset mid-word.
        step(0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst down_valid", dv[0], 1'b0);
        chk("async_rst up_ready", ur[0], 1'b1);
        chk("async_rst down_last", dl[0], 1'b0);
        exp_q.delete();
        uv[0] = 1'b1;
        dr[0] = 1'b1;
        ud    = 8'h55;
        @(posedge clk);
        #1;
        chk("in_rst down_valid", dv[0], 1'b0);
        @(negedge clk);
        uv    = '0;
        dr    = '0;
        rst_n = 1'b1;
        step(0, 1'b1, 8'h80, 1'b1);
        drain(0);

        // Three-bit instance.
        step(2, 1'b1, 8'h06, 1'b1);
        drain(2);

        // Random traffic on each instance.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 300; i++) begin
                step(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 3) != 0));
            end
            drain(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
